// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  // Controller state: normal issue or waiting on a data-cache miss
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_e;

  // Width of the MEM_WAIT cycle counter (saturates at 1023)
  localparam int WAIT_W = 10;

  // Register $zero never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_sat_cnt.sv
// rtl/hazard_sat_cnt.sv - saturating event counter with sync clear and increment enable
//
// Ports:
//   clk_i  clock
//   clr_i  synchronous clear, wins over increment
//   inc_i  count one event at this edge
//   cnt_o  current count, holds at all-ones
module hazard_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush controller for the five-stage pipeline (load-use, cache miss, branch)
//
// Optional feature macro: HAZARD_PERF_EN (builds the three performance counters;
// without it the counter outputs are tied to zero).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   IDEX_memread_i/rt_i   load in EX and its destination register
//   IFID_rs_i/rt_i        source registers of the instruction in ID
//   branch_taken_i        branch in ID resolved taken
//   mem_req_i/mem_ack_i   data-cache access pending / completing this cycle
//   pc_write_o            PC may update
//   IFID_write_o          IF/ID may update
//   IDEX_bubble_o         zero ID/EX control fields
//   IFID_flush_o          clear IF/ID to nop
//   freeze_o              hold ID/EX, EX/MEM, MEM/WB
//   err_o                 sticky MEM_WAIT timeout
//   *_cnt_o               load-use bubbles, frozen cycles, flushes issued
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_memread_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             IFID_write_o,
  output logic             IDEX_bubble_o,
  output logic             IFID_flush_o,
  output logic             freeze_o,
  output logic             err_o,
  output logic [CNT_W-1:0] loaduse_cnt_o,
  output logic [CNT_W-1:0] memstall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [WAIT_W-1:0] TIMEOUT_C = TIMEOUT[WAIT_W-1:0];

  hazard_state_e     r_state;
  hazard_state_e     w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_err;
  logic              w_freeze_cond;
  logic              w_loaduse;

  // Freeze is evaluated in both states so a cache hit never stalls and the
  // ack cycle itself is already unfrozen.
  assign w_freeze_cond = mem_req_i & ~mem_ack_i;
  assign w_loaduse     = IDEX_memread_i && (IDEX_rt_i != REG_ZERO) &&
                         ((IDEX_rt_i == IFID_rs_i) || (IDEX_rt_i == IFID_rt_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if ((r_state == MEM_WAIT) && (r_wait_cnt >= TIMEOUT_C)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (w_freeze_cond) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        // A stray ack (no request) still closes out the wait.
        if (mem_ack_i) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else if (r_wait_cnt != '1) begin
          w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Priority: freeze > load-use > taken branch. A load-use seen while frozen is
  // simply not acted on; ID/EX is held, so it re-evaluates once unfrozen and
  // yields exactly one bubble. A branch under a load-use waits for the bubble.
  always_comb begin
    pc_write_o    = 1'b1;
    IFID_write_o  = 1'b1;
    IDEX_bubble_o = 1'b0;
    IFID_flush_o  = 1'b0;
    freeze_o      = 1'b0;
    if (!rst_i) begin
      if (w_freeze_cond) begin
        freeze_o     = 1'b1;
        pc_write_o   = 1'b0;
        IFID_write_o = 1'b0;
      end else if (w_loaduse) begin
        pc_write_o    = 1'b0;
        IFID_write_o  = 1'b0;
        IDEX_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
        IFID_flush_o = 1'b1;
      end
    end
  end

  assign err_o = r_err;

`ifdef HAZARD_PERF_EN
  hazard_sat_cnt #(.W(CNT_W)) u_loaduse_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (IDEX_bubble_o),
    .cnt_o (loaduse_cnt_o)
  );

  hazard_sat_cnt #(.W(CNT_W)) u_memstall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (freeze_o),
    .cnt_o (memstall_cnt_o)
  );

  hazard_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (IFID_flush_o),
    .cnt_o (flush_cnt_o)
  );
`else
  assign loaduse_cnt_o  = '0;
  assign memstall_cnt_o = '0;
  assign flush_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int TIMEOUT = 5;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i;
  logic             IDEX_memread_i;
  logic [4:0]       IDEX_rt_i;
  logic [4:0]       IFID_rs_i;
  logic [4:0]       IFID_rt_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             pc_write_o;
  logic             IFID_write_o;
  logic             IDEX_bubble_o;
  logic             IFID_flush_o;
  logic             freeze_o;
  logic             err_o;
  logic [CNT_W-1:0] loaduse_cnt_o;
  logic [CNT_W-1:0] memstall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_lu = 0;
  int exp_ms = 0;
  int exp_fl = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .IDEX_memread_i (IDEX_memread_i),
    .IDEX_rt_i      (IDEX_rt_i),
    .IFID_rs_i      (IFID_rs_i),
    .IFID_rt_i      (IFID_rt_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .pc_write_o     (pc_write_o),
    .IFID_write_o   (IFID_write_o),
    .IDEX_bubble_o  (IDEX_bubble_o),
    .IFID_flush_o   (IFID_flush_o),
    .freeze_o       (freeze_o),
    .err_o          (err_o),
    .loaduse_cnt_o  (loaduse_cnt_o),
    .memstall_cnt_o (memstall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pc_write, IFID_write, bubble, flush, freeze
  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {pc_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o, freeze_o}, {27'd0, exp});
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_lu"}, {28'd0, loaduse_cnt_o},  PERF ? exp_lu : 0);
    chk({tag, "_ms"}, {28'd0, memstall_cnt_o}, PERF ? exp_ms : 0);
    chk({tag, "_fl"}, {28'd0, flush_cnt_o},    PERF ? exp_fl : 0);
  endtask

  task automatic idle();
    IDEX_memread_i = 1'b0;
    IDEX_rt_i      = 5'd0;
    IFID_rs_i      = 5'd0;
    IFID_rt_i      = 5'd0;
    branch_taken_i = 1'b0;
    mem_req_i      = 1'b0;
    mem_ack_i      = 1'b0;
  endtask

  initial begin
    // Reset with every hazard source active: outputs must stay neutral
    idle();
    rst_i = 1'b1;
    mem_req_i = 1'b1;
    IDEX_memread_i = 1'b1; IDEX_rt_i = 5'd8; IFID_rs_i = 5'd8;
    branch_taken_i = 1'b1;
    @(negedge clk); #1;
    chk_out("rst_outputs", 5'b11000);
    @(negedge clk); #1;
    chk("rst_state", dut.r_state, RUN);
    chk("rst_wait", dut.r_wait_cnt, 0);
    chk("rst_err", err_o, 0);
    chk_cnts("rst");
    rst_i = 1'b0;
    idle(); #1;
    chk_out("idle", 5'b11000);

    // Load-use on rs, then on rt
    IDEX_memread_i = 1'b1; IDEX_rt_i = 5'd8; IFID_rs_i = 5'd8; IFID_rt_i = 5'd0; #1;
    chk_out("lu_rs", 5'b00100);
    @(negedge clk); exp_lu++;
    IFID_rs_i = 5'd3; IFID_rt_i = 5'd8; #1;
    chk_out("lu_rt", 5'b00100);
    @(negedge clk); exp_lu++;
    // $zero destination and non-load never bubble
    IDEX_rt_i = 5'd0; IFID_rs_i = 5'd0; IFID_rt_i = 5'd0; #1;
    chk_out("lu_zero", 5'b11000);
    IDEX_memread_i = 1'b0; IDEX_rt_i = 5'd8; IFID_rs_i = 5'd8; #1;
    chk_out("lu_noload", 5'b11000);
    @(negedge clk); #1;
    chk_cnts("lu");

    // Taken branch alone
    idle(); branch_taken_i = 1'b1; #1;
    chk_out("branch", 5'b11010);
    @(negedge clk); exp_fl++;
    idle();

    // Cache hit: no freeze, remain RUN
    mem_req_i = 1'b1; mem_ack_i = 1'b1; #1;
    chk_out("hit", 5'b11000);
    @(negedge clk); #1;
    chk("hit_state", dut.r_state, RUN);

    // 4-cycle miss
    mem_ack_i = 1'b0; #1;
    chk_out("miss_c0", 5'b00001);
    @(negedge clk); #1;
    chk("miss_state", dut.r_state, MEM_WAIT);
    chk_out("miss_c1", 5'b00001);
    @(negedge clk); #1;
    chk_out("miss_c2", 5'b00001);
    @(negedge clk);
    mem_ack_i = 1'b1; #1;
    chk_out("miss_ack", 5'b11000);
    exp_ms += 3;
    @(negedge clk);
    idle(); #1;
    chk("miss_run", dut.r_state, RUN);
    chk("miss_wait0", dut.r_wait_cnt, 0);
    chk_cnts("miss");

    // Freeze dominates load-use and branch
    mem_req_i = 1'b1; mem_ack_i = 1'b0;
    IDEX_memread_i = 1'b1; IDEX_rt_i = 5'd8; IFID_rs_i = 5'd8; branch_taken_i = 1'b1; #1;
    chk_out("dom_c0", 5'b00001);
    @(negedge clk); #1;
    chk_out("dom_c1", 5'b00001);
    @(negedge clk); exp_ms += 2;
    mem_ack_i = 1'b1; #1;
    chk_out("dom_ack_bubble", 5'b00100);
    @(negedge clk); exp_lu++;
    idle(); branch_taken_i = 1'b1; #1;
    chk_out("dom_branch", 5'b11010);
    @(negedge clk); exp_fl++;
    idle(); #1;
    chk("dom_state", dut.r_state, RUN);
    chk_cnts("dom");

    // Timeout: err after TIMEOUT cycles in MEM_WAIT, sticky across ack
    mem_req_i = 1'b1; mem_ack_i = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("to_err_early", err_o, 0);
    @(negedge clk); #1;
    exp_ms += 6;
    chk("to_err_set", err_o, 1);
    mem_req_i = 1'b0; #1;
    chk_out("to_noreq", 5'b11000);
    @(negedge clk); #1;
    chk("to_still_wait", dut.r_state, MEM_WAIT);
    chk("to_err_hold", err_o, 1);
    mem_ack_i = 1'b1;
    @(negedge clk); #1;
    idle();
    chk("to_run", dut.r_state, RUN);
    chk("to_err_sticky", err_o, 1);
    chk_cnts("to");

    // Reset arriving mid-miss
    mem_req_i = 1'b1; mem_ack_i = 1'b0;
    @(negedge clk); #1;
    chk("rm_wait", dut.r_state, MEM_WAIT);
    rst_i = 1'b1; #1;
    chk_out("rm_outputs", 5'b11000);
    @(negedge clk); #1;
    exp_lu = 0; exp_ms = 0; exp_fl = 0;
    chk("rm_state", dut.r_state, RUN);
    chk("rm_wait_cnt", dut.r_wait_cnt, 0);
    chk("rm_err", err_o, 0);
    chk_cnts("rm");
    rst_i = 1'b0;
    idle();

    // 20 consecutive bubbles saturate the 4-bit counter
    IDEX_memread_i = 1'b1; IDEX_rt_i = 5'd8; IFID_rs_i = 5'd8;
    repeat (20) @(negedge clk);
    exp_lu = CMAX;
    #1;
    chk_cnts("sat");
    idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
